// File: rtl/meter_pkg.sv
// Shared types and constants for the voltmeter sequencer.
package meter_pkg;

    // Conversion/averaging controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    // Digit-scan indices, least significant digit first.
    localparam logic [1:0] DIGIT_ONES      = 2'd0;
    localparam logic [1:0] DIGIT_TENS      = 2'd1;
    localparam logic [1:0] DIGIT_HUNDREDS  = 2'd2;
    localparam logic [1:0] DIGIT_THOUSANDS = 2'd3;

    // Largest value a four-digit display can show.
    localparam int DEFAULT_FULL_SCALE = 9999;

endpackage

// File: rtl/meter_sequencer_digit_scanner.sv
// Digit-scan timing: slot counter, digit select, inter-digit blanking and
// a strobe marking the last cycle of the thousands slot (frame boundary).
module digit_scanner
    import meter_pkg::*;
#(
    parameter int DIGIT_CYCLES = 2080,
    parameter int BLANK_CYCLES = 32
) (
    input  logic       clk_i,
    input  logic       reset,
    output logic [1:0] digit_sel,
    output logic       digit_blank,
    output logic       frame_wrap
);

    localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);

    logic [SLOT_W-1:0] slot_cnt;
    logic [SLOT_W-1:0] slot_next;
    logic              slot_wrap;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign slot_next  = slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
    // Next clock edge moves digit_sel from thousands back to ones.
    assign frame_wrap = slot_wrap && (digit_sel == DIGIT_THOUSANDS);

    // Advance the slot counter and digit index; blanking is registered from
    // the next slot count so it lines up with the slot it belongs to.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            digit_sel   <= DIGIT_ONES;
            digit_blank <= 1'b0;
        end else begin
            slot_cnt    <= slot_next;
            digit_blank <= (slot_next < BLANK_END);
            if (slot_wrap) begin
                digit_sel <= digit_sel + 2'd1;
            end
        end
    end

endmodule

// File: rtl/meter_sequencer.sv
// Voltmeter controller: periodic ADC batch acquisition with averaging,
// clamping to display full scale, tear-free hand-off to the parser at the
// digit-scan frame boundary, and the digit-scan timing itself.
// Optional: define ADC_TIMEOUT_EN to abort a batch (and raise sticky
// adc_error) when adc_done does not arrive within TIMEOUT_CYCLES in WAIT.
module meter_sequencer
    import meter_pkg::*;
#(
    parameter int SAMPLE_PERIOD  = 208000,
    parameter int AVG_LOG2       = 2,
    parameter int DIGIT_CYCLES   = 2080,
    parameter int BLANK_CYCLES   = 32,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int FULL_SCALE     = DEFAULT_FULL_SCALE
) (
    input  logic        clk_i,
    input  logic        reset,
    output logic        adc_start,
    input  logic        adc_busy,
    input  logic        adc_done,
    input  logic [15:0] adc_data,
    input  logic        hold_i,
    output logic [15:0] display_data,
    output logic        display_valid,
    output logic        overrange,
    output logic        adc_error,
    output logic [1:0]  digit_sel,
    output logic        digit_blank
);

    localparam int SUM_W = 16 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_LAST       = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST    = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SUM_W-1:0] FULL_SCALE_SUM = SUM_W'(FULL_SCALE);
    localparam logic [15:0]      FULL_SCALE_16  = 16'(FULL_SCALE);

    state_t            state;
    logic              pend_batch;
    logic [PER_W-1:0]  per_cnt;
    logic              per_wrap;
    logic [SUM_W-1:0]  sum;
    logic [CNT_W-1:0]  sample_cnt;
    logic [15:0]       shadow;
    logic              ovr_shadow;
    logic              shadow_new;
    logic              frame_wrap;

`ifdef ADC_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]  tmo_cnt;
`endif

    // Truncating average of a full batch.
    function automatic logic [SUM_W-1:0] batch_avg(input logic [SUM_W-1:0] s);
        return s >> AVG_LOG2;
    endfunction

    // Clamp to display full scale; result is {overrange, value}.
    function automatic logic [16:0] saturate(input logic [SUM_W-1:0] avg);
        logic [16:0] res;
        if (avg > FULL_SCALE_SUM) begin
            res = {1'b1, FULL_SCALE_16};
        end else begin
            res = {1'b0, avg[15:0]};
        end
        return res;
    endfunction

    assign per_wrap = (per_cnt == PER_LAST);

    // Free-running batch period timer.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_wrap ? '0 : per_cnt + PER_W'(1);
        end
    end

    // Batch FSM: request conversions, accumulate, then compute the clamped
    // average into the shadow register. A period wrap during a batch only
    // sets pend_batch, so at most one further batch is ever owed.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pend_batch <= 1'b0;
            adc_start  <= 1'b0;
            sum        <= '0;
            sample_cnt <= '0;
            shadow     <= '0;
            ovr_shadow <= 1'b0;
`ifdef ADC_TIMEOUT_EN
            tmo_cnt    <= '0;
            adc_error  <= 1'b0;
`endif
        end else begin
            adc_start <= 1'b0;
            if (per_wrap) begin
                pend_batch <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pend_batch) begin
                        state      <= START;
                        // A wrap landing on this very cycle still counts.
                        pend_batch <= per_wrap;
                    end
                end
                START: begin
                    if (!adc_busy) begin
                        adc_start <= 1'b1;
                        state     <= WAIT;
`ifdef ADC_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (adc_done) begin
                        sum <= sum + SUM_W'(adc_data);
                        if (sample_cnt == SAMPLE_LAST) begin
                            state <= PUBLISH;
                        end else begin
                            sample_cnt <= sample_cnt + CNT_W'(1);
                            state      <= START;
                        end
                    end
`ifdef ADC_TIMEOUT_EN
                    // adc_done takes precedence in the expiry cycle.
                    else if (tmo_cnt == TMO_LAST) begin
                        adc_error  <= 1'b1;
                        sum        <= '0;
                        sample_cnt <= '0;
                        state      <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                PUBLISH: begin
                    {ovr_shadow, shadow} <= saturate(batch_avg(sum));
                    sum        <= '0;
                    sample_cnt <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef ADC_TIMEOUT_EN
    assign adc_error = 1'b0;
`endif

    // Hand a fresh result to the parser only at the frame boundary so the
    // four digits of one scan always come from the same batch; while held,
    // newer batches keep overwriting the shadow and stay pending.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            display_data  <= '0;
            display_valid <= 1'b0;
            overrange     <= 1'b0;
            shadow_new    <= 1'b0;
        end else begin
            if (frame_wrap && shadow_new && !hold_i) begin
                display_data  <= shadow;
                overrange     <= ovr_shadow;
                display_valid <= 1'b1;
                shadow_new    <= 1'b0;
            end
            if (state == PUBLISH) begin
                shadow_new <= 1'b1;
            end
        end
    end

    digit_scanner #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan (
        .clk_i       (clk_i),
        .reset       (reset),
        .digit_sel   (digit_sel),
        .digit_blank (digit_blank),
        .frame_wrap  (frame_wrap)
    );

endmodule

// File: doc/meter_sequencer.md
Name: meter_sequencer

Overview:
- Controller for the voltmeter datapath.
- Periodically triggers ADC conversions over a start/busy/done handshake and averages 2^AVG_LOG2 samples.
- Clamps the average to display full scale and publishes it tear-free to the parser.
- Generates the digit-scan select and inter-digit blanking that drive the display mux.

Parameters:
- SAMPLE_PERIOD, 208000: clk_i cycles between batch starts (10 Hz at 2.08 MHz).
- AVG_LOG2, 2: log2 of samples per batch (0..4).
- DIGIT_CYCLES, 2080: clk_i cycles per digit slot.
- BLANK_CYCLES, 32: leading cycles of each slot with blanking asserted; must be < DIGIT_CYCLES.
- TIMEOUT_CYCLES, 4096: max cycles waiting for adc_done.
- FULL_SCALE, 9999: clamp value for the displayed result.

Ports:
- clk_i, in, 1: system clock (2.08 MHz oscillator).
- reset, in, 1: asynchronous, active-high reset.
- adc_start, out, 1: one-cycle conversion request.
- adc_busy, in, 1: ADC conversion in progress.
- adc_done, in, 1: one-cycle pulse; adc_data is valid in this cycle.
- adc_data, in, 16: raw conversion result.
- hold_i, in, 1: freeze the displayed value.
- display_data, out, 16: value to the parser.
- display_valid, out, 1: at least one batch has been displayed.
- overrange, out, 1: last published batch was clamped.
- adc_error, out, 1: sticky conversion timeout flag.
- digit_sel, out, 2: digit index, 0 = ones … 3 = thousands.
- digit_blank, out, 1: segments must be off.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; sum, counters and shadow register cleared.
- Reset asserted mid-batch aborts the batch; nothing is published.
- Period counter: free-running, wraps at SAMPLE_PERIOD-1. Its wrap sets pend_batch, cleared on IDLE->START. A wrap during a batch is remembered once, never queued twice.
- FSM states and transitions:
  - IDLE: go to START when pend_batch is set.
  - START: adc_start=1 for exactly one cycle while adc_busy=0, then go to WAIT. If adc_busy=1, stay in START with adc_start=0.
  - WAIT: on adc_done, add adc_data into an unsigned sum of width 16+AVG_LOG2. If the sample count reaches 2^AVG_LOG2, go to PUBLISH; otherwise go to START. The timeout counter restarts on entry to WAIT.
  - PUBLISH (1 cycle):
    - avg = sum >> AVG_LOG2 (truncating).
    - If avg > FULL_SCALE: shadow = FULL_SCALE, ovr_shadow = 1; else shadow = avg, ovr_shadow = 0.
    - Set shadow_new; clear sum and count; go to IDLE.
- adc_done while not in WAIT is ignored.
- Display transfer happens only at the slot boundary where digit_sel wraps 3->0, and only when shadow_new=1 and hold_i=0:
  - display_data <= shadow; overrange <= ovr_shadow; display_valid <= 1; shadow_new cleared.
  - While hold_i=1, shadow_new stays set and the newest batch overwrites shadow.
- Digit scan: slot counter 0..DIGIT_CYCLES-1.
  - At wrap, digit_sel increments modulo 4.
  - digit_blank=1 while slot counter < BLANK_CYCLES.
  - The scan runs independently of the FSM and of hold_i.
- Latency: display_data updates 1 to 4*DIGIT_CYCLES cycles after PUBLISH.

Optional Feature:
- Macro: ADC_TIMEOUT_EN.
- Defined:
  - If TIMEOUT_CYCLES elapse in WAIT without adc_done: set adc_error (sticky until reset), discard the partial sum, go to IDLE; nothing is published.
  - If adc_done arrives in the cycle the timeout expires, adc_done wins.
- Undefined: WAIT has no timeout and adc_error is tied to 0.

Decomposition:
- Package meter_pkg: FSM state enum (IDLE, START, WAIT, PUBLISH); DIGIT_ONES..DIGIT_THOUSANDS constants; default FULL_SCALE.
- One sub-module, digit_scanner: slot counter, digit_sel, digit_blank and the wrap strobe consumed by the transfer logic.

Test Plan (bench parameters: SAMPLE_PERIOD=200, DIGIT_CYCLES=10, BLANK_CYCLES=2, TIMEOUT_CYCLES=50, AVG_LOG2=2):
- Samples 100,101,102,103 -> display_data=101, overrange=0, display_valid=1 at the next 3->0 wrap; exactly 4 adc_start pulses.
- Four samples of 12000 -> display_data=9999, overrange=1.
- adc_busy held high for 7 cycles in START -> adc_start is asserted only in the first cycle after busy falls.
- With ADC_TIMEOUT_EN, no adc_done -> adc_error=1 after 50 cycles and display_data unchanged; same test with adc_done on cycle 50 -> sample accepted, adc_error=0.
- hold_i=1 across two batches (200, then 300) -> display_data stays 0; after release, 300 appears at the next 3->0 wrap.
- Reset pulse in WAIT after 2 of 4 samples -> all outputs 0; next batch 40,40,40,40 -> 40, with no contribution from the pre-reset samples.
- Scan check -> digit_sel cycles 0,1,2,3,0 every 10 cycles, with digit_blank high for the first 2 cycles of each slot.
